// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
//   lsu_state_e  : sequencer FSM states
//   lsu_ld_ctx_t : request context kept for load formatting
//   SZ_*         : funct3[1:0] access sizes
//   CAUSE_*      : resp_cause encodings
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_MISAL   = 2'd1;
  localparam logic [1:0] CAUSE_BUSERR  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef struct packed {
    logic [2:0] fn3;
    logic [1:0] off;
  } lsu_ld_ctx_t;

  // Size 3 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response and data-bus signals of lsu_ctrl.
//   master : the sequencer's view (drives req_ready, mem_*, resp_*)
//   slave  : the environment's view (core plus memory)
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_fn3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_cause;

  modport master (
    input  req_valid, req_we, req_fn3, req_addr, req_wdata,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output resp_valid, resp_rdata, resp_err, resp_cause,
    input  resp_ready
  );

  modport slave (
    output req_valid, req_we, req_fn3, req_addr, req_wdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  resp_valid, resp_rdata, resp_err, resp_cause,
    output resp_ready
  );
endinterface

// File: rtl/input_adj.sv
// Load formatter: selects the addressed byte/half/word from a big-endian
// bus word and returns it little-endian, sign- or zero-extended.
//   bus_data    : big-endian read word
//   fn3         : funct3; [1:0] size, [2] unsigned
//   offset      : byte offset addr[1:0]
//   core_data_c : formatted load value
module input_adj
  import lsu_pkg::*;
(
  input  logic [31:0] bus_data,
  input  logic [2:0]  fn3,
  input  logic [1:0]  offset,
  output logic [31:0] core_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = bus_data[31:24];
      2'd1:    byte_sel = bus_data[23:16];
      2'd2:    byte_sel = bus_data[15:8];
      default: byte_sel = bus_data[7:0];
    endcase
    half_sel = offset[1] ? {bus_data[7:0], bus_data[15:8]}
                         : {bus_data[23:16], bus_data[31:24]};
    sext        = 1'b0;
    core_data_c = '0;
    case (fn3[1:0])
      SZ_BYTE: begin
        sext        = ~fn3[2] & byte_sel[7];
        core_data_c = {{24{sext}}, byte_sel};
      end
      SZ_HALF: begin
        sext        = ~fn3[2] & half_sel[15];
        core_data_c = {{16{sext}}, half_sel};
      end
      default: core_data_c = {bus_data[7:0], bus_data[15:8], bus_data[23:16], bus_data[31:24]};
    endcase
  end

endmodule

// File: rtl/store_adj.sv
// Combinational store lane steering and byte-enable generation.
//   we         : 1 = store (data steered), 0 = load (data forced to 0)
//   size       : funct3[1:0]
//   offset     : byte offset addr[1:0]
//   core_data  : little-endian store data from the core
//   be_c       : byte enables, be_c[3] = offset 0
//   bus_data_c : big-endian lane data, replicated across unused lanes
module store_adj
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] core_data,
  output logic [3:0]  be_c,
  output logic [31:0] bus_data_c
);

  always_comb begin
    be_c       = 4'b0000;
    bus_data_c = '0;
    case (size)
      SZ_BYTE: begin
        be_c       = 4'b1000 >> offset;
        bus_data_c = {4{core_data[7:0]}};
      end
      SZ_HALF: begin
        be_c       = offset[1] ? 4'b0011 : 4'b1100;
        bus_data_c = {2{core_data[7:0], core_data[15:8]}};
      end
      default: begin
        be_c       = 4'b1111;
        bus_data_c = {core_data[7:0], core_data[15:8], core_data[23:16], core_data[31:24]};
      end
    endcase
    if (!we) begin
      bus_data_c = '0;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the memory stage and a big-endian 32-bit bus.
// One request at a time: alignment check, bus request/grant, response or
// timeout, then a held result towards the core.
//   clk, rst : clock, synchronous active-high reset
//   bus      : core request/response and data-bus signals (master view)
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       rst,
  lsu_ctrl_if.master bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lsu_ld_ctx_t ctx_q, ctx_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [1:0]  resp_cause_q, resp_cause_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        timeout_hit;
  logic        do_timeout;

  // Lanes are steered from the live request so they can be registered on accept.
  store_adj u_store_adj (
    .we         (bus.req_we),
    .size       (bus.req_fn3[1:0]),
    .offset     (bus.req_addr[1:0]),
    .core_data  (bus.req_wdata),
    .be_c       (st_be),
    .bus_data_c (st_wdata)
  );

  input_adj u_input_adj (
    .bus_data    (bus.mem_rdata),
    .fn3         (ctx_q.fn3),
    .offset      (ctx_q.off),
    .core_data_c (ld_data)
  );

  assign timeout_hit = (cnt_q == CNT_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ctx_d        = ctx_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    resp_cause_d = resp_cause_q;
    do_timeout   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          ctx_d.fn3   = bus.req_fn3;
          ctx_d.off   = bus.req_addr[1:0];
          mem_we_d    = bus.req_we;
          mem_addr_d  = {bus.req_addr[31:2], 2'b00};
          mem_be_d    = st_be;
          mem_wdata_d = st_wdata;
          cnt_d       = '0;
          if (is_misaligned(bus.req_fn3[1:0], bus.req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
            resp_cause_d = CAUSE_MISAL;
          end else begin
            state_d   = ST_REQ;
            mem_req_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Grant beats a simultaneous timeout.
        if (bus.mem_gnt) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end else if (timeout_hit) begin
          do_timeout = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Response beats a simultaneous timeout.
        if (bus.mem_rvalid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = (mem_we_q || bus.mem_err) ? '0 : ld_data;
          resp_err_d   = bus.mem_err;
          resp_cause_d = bus.mem_err ? CAUSE_BUSERR : CAUSE_NONE;
        end else if (timeout_hit) begin
          do_timeout = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_timeout) begin
      state_d      = ST_RESP;
      mem_req_d    = 1'b0;
      resp_valid_d = 1'b1;
      resp_rdata_d = '0;
      resp_err_d   = 1'b1;
      resp_cause_d = CAUSE_TIMEOUT;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ctx_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      resp_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctx_q        <= ctx_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_cause_q <= resp_cause_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_cause = resp_cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed and random transactions on a default
// instance, timeout corner cases on a TIMEOUT_CYCLES=4 instance.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_ctrl_if bm ();
  lsu_ctrl_if bt ();

  lsu_ctrl #(.TIMEOUT_CYCLES(255)) u_dut (.clk(clk), .rst(rst), .bus(bm));
  lsu_ctrl #(.TIMEOUT_CYCLES(4))   u_dut_to (.clk(clk), .rst(rst), .bus(bt));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: byte-level view of the bus word ----------------
  function automatic int nbytes(input logic [2:0] fn3);
    case (fn3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic m_misal(input logic [2:0] fn3, input logic [31:0] addr);
    return (int'(addr[1:0]) % nbytes(fn3)) != 0;
  endfunction

  // Bus offset k lives in be[3-k] / data[31-8k -: 8].
  function automatic logic [3:0] m_be(input logic [2:0] fn3, input logic [31:0] addr);
    logic [3:0] be = '0;
    int off = int'(addr[1:0]);
    for (int k = 0; k < 4; k++)
      if (k >= off && k < off + nbytes(fn3)) be[3-k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic we, input logic [2:0] fn3, input logic [31:0] wd);
    logic [31:0] w = '0;
    if (!we) return '0;
    for (int k = 0; k < 4; k++)
      w[31-8*k -: 8] = wd[8*(k % nbytes(fn3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] fn3, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v = '0;
    int off = int'(addr[1:0]);
    int n = nbytes(fn3);
    for (int i = 0; i < n; i++)
      v[8*i +: 8] = rd[31-8*(off+i) -: 8];
    if (!fn3[2] && n < 4 && v[8*n-1])
      for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
    return v;
  endfunction

  // One full transaction on the default instance; starts and ends just after a negedge.
  task automatic do_txn(input logic we, input logic [2:0] fn3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input logic err, input int rr_dly);
    logic        misal;
    logic [31:0] exp_rd;
    misal  = m_misal(fn3, addr);
    exp_rd = (we || err || misal) ? 32'h0 : m_load(fn3, addr, rdata);
    chk("req_ready_idle", 32'(bm.req_ready), 32'd1);
    bm.req_valid = 1'b1;
    bm.req_we    = we;
    bm.req_fn3   = fn3;
    bm.req_addr  = addr;
    bm.req_wdata = wdata;
    @(negedge clk);
    bm.req_valid = 1'b0;
    bm.req_addr  = $urandom();
    bm.req_wdata = $urandom();
    if (misal) begin
      chk("misal_no_mem_req", 32'(bm.mem_req), 32'd0);
      chk("misal_resp_valid", 32'(bm.resp_valid), 32'd1);
      chk("misal_err", 32'(bm.resp_err), 32'd1);
      chk("misal_cause", 32'(bm.resp_cause), 32'd1);
      chk("misal_rdata", bm.resp_rdata, 32'd0);
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        chk("mem_req_held", 32'(bm.mem_req), 32'd1);
        if (i == 0) begin
          chk("mem_addr", bm.mem_addr, {addr[31:2], 2'b00});
          chk("mem_be", 32'(bm.mem_be), 32'(m_be(fn3, addr)));
          chk("mem_wdata", bm.mem_wdata, m_wdata(we, fn3, wdata));
          chk("mem_we", 32'(bm.mem_we), 32'(we));
        end
        bm.mem_gnt = (i == gnt_dly);
        @(negedge clk);
      end
      bm.mem_gnt = 1'b0;
      for (int j = 0; j <= rv_dly; j++) begin
        chk("mem_req_dropped", 32'(bm.mem_req), 32'd0);
        chk("resp_valid_wait", 32'(bm.resp_valid), 32'd0);
        bm.mem_rvalid = (j == rv_dly);
        bm.mem_rdata  = (j == rv_dly) ? rdata : $urandom();
        bm.mem_err    = (j == rv_dly) ? err : 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bm.mem_rvalid = 1'b0;
      bm.mem_err    = 1'b0;
      bm.mem_rdata  = $urandom();
      chk("resp_valid", 32'(bm.resp_valid), 32'd1);
      chk("resp_rdata", bm.resp_rdata, exp_rd);
      chk("resp_err", 32'(bm.resp_err), 32'(err));
      chk("resp_cause", 32'(bm.resp_cause), err ? 32'd2 : 32'd0);
    end
    for (int k = 0; k < rr_dly; k++) begin
      @(negedge clk);
      chk("resp_valid_hold", 32'(bm.resp_valid), 32'd1);
      chk("resp_rdata_hold", bm.resp_rdata, exp_rd);
      chk("req_ready_busy", 32'(bm.req_ready), 32'd0);
    end
    bm.resp_ready = 1'b1;
    @(negedge clk);
    bm.resp_ready = 1'b0;
    chk("resp_valid_clear", 32'(bm.resp_valid), 32'd0);
    chk("req_ready_back", 32'(bm.req_ready), 32'd1);
  endtask

  task automatic bt_accept(input logic [31:0] addr);
    bt.req_valid = 1'b1;
    bt.req_we    = 1'b0;
    bt.req_fn3   = 3'd2;
    bt.req_addr  = addr;
    bt.req_wdata = '0;
    @(negedge clk);
    bt.req_valid = 1'b0;
  endtask

  task automatic bt_finish();
    bt.resp_ready = 1'b1;
    @(negedge clk);
    bt.resp_ready = 1'b0;
    chk("to_req_ready_back", 32'(bt.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    bm.req_valid = 0; bm.req_we = 0; bm.req_fn3 = 0; bm.req_addr = 0; bm.req_wdata = 0;
    bm.mem_gnt = 0; bm.mem_rvalid = 0; bm.mem_rdata = 0; bm.mem_err = 0; bm.resp_ready = 0;
    bt.req_valid = 0; bt.req_we = 0; bt.req_fn3 = 0; bt.req_addr = 0; bt.req_wdata = 0;
    bt.mem_gnt = 0; bt.mem_rvalid = 0; bt.mem_rdata = 0; bt.mem_err = 0; bt.resp_ready = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_req_ready", 32'(bm.req_ready), 32'd1);
    chk("rst_mem_req", 32'(bm.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bm.mem_we), 32'd0);
    chk("rst_mem_addr", bm.mem_addr, 32'd0);
    chk("rst_mem_be", 32'(bm.mem_be), 32'd0);
    chk("rst_mem_wdata", bm.mem_wdata, 32'd0);
    chk("rst_resp_valid", 32'(bm.resp_valid), 32'd0);
    chk("rst_resp_rdata", bm.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bm.resp_err), 32'd0);
    chk("rst_resp_cause", 32'(bm.resp_cause), 32'd0);
    chk("rst_to_req_ready", 32'(bt.req_ready), 32'd1);

    // Directed cases
    do_txn(1'b0, 3'd0, 32'h0000_0103, 32'h0, 0, 0, 32'h1122_33F0, 1'b0, 0);  // lb
    do_txn(1'b0, 3'd5, 32'h0000_0202, 32'h0, 5, 0, 32'hAABB_8001, 1'b0, 0);  // lhu
    do_txn(1'b1, 3'd2, 32'h0000_0300, 32'h1122_3344, 1, 2, 32'h5555_AAAA, 1'b0, 0); // sw
    do_txn(1'b1, 3'd0, 32'h0000_0301, 32'h1234_56AB, 0, 0, 32'h0, 1'b0, 0);  // sb
    do_txn(1'b0, 3'd2, 32'h0000_0402, 32'h0, 0, 0, 32'h0, 1'b0, 0);          // lw misaligned
    do_txn(1'b0, 3'd1, 32'h0000_0401, 32'h0, 0, 0, 32'h0, 1'b0, 0);          // lh misaligned
    do_txn(1'b0, 3'd2, 32'h0000_0404, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0, 10); // held response
    do_txn(1'b0, 3'd3, 32'h0000_0408, 32'h0, 0, 0, 32'h0102_0304, 1'b0, 0);  // size 3 as word
    do_txn(1'b0, 3'd4, 32'h0000_0502, 32'h0, 2, 3, 32'h0102_0304, 1'b1, 1);  // bus error

    // Stray grant/response while idle
    bm.mem_gnt = 1'b1; bm.mem_rvalid = 1'b1;
    @(negedge clk);
    bm.mem_gnt = 1'b0; bm.mem_rvalid = 1'b0;
    chk("idle_stray_mem_req", 32'(bm.mem_req), 32'd0);
    chk("idle_stray_resp_valid", 32'(bm.resp_valid), 32'd0);
    chk("idle_stray_req_ready", 32'(bm.req_ready), 32'd1);

    // Reset while waiting for the response
    bm.req_valid = 1'b1; bm.req_we = 1'b0; bm.req_fn3 = 3'd2; bm.req_addr = 32'h600;
    @(negedge clk);
    bm.req_valid = 1'b0; bm.mem_gnt = 1'b1;
    @(negedge clk);
    bm.mem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_mem_req", 32'(bm.mem_req), 32'd0);
    chk("midrst_resp_valid", 32'(bm.resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(bm.req_ready), 32'd1);
    bm.mem_rvalid = 1'b1;
    @(negedge clk);
    bm.mem_rvalid = 1'b0;
    chk("midrst_late_rvalid", 32'(bm.resp_valid), 32'd0);

    // Random transactions
    for (int t = 0; t < 60; t++) begin
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(),
             int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), $urandom(),
             ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
    end

    // Timeout after grant, no response: 4 REQ+WAIT cycles
    bt_accept(32'h500);
    chk("to_a_mem_req", 32'(bt.mem_req), 32'd1);
    bt.mem_gnt = 1'b1;
    @(negedge clk);
    bt.mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("to_a_not_yet", 32'(bt.resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("to_a_resp_valid", 32'(bt.resp_valid), 32'd1);
    chk("to_a_err", 32'(bt.resp_err), 32'd1);
    chk("to_a_cause", 32'(bt.resp_cause), 32'd3);
    chk("to_a_rdata", bt.resp_rdata, 32'd0);
    bt_finish();
    bt.mem_rvalid = 1'b1; bt.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    bt.mem_rvalid = 1'b0;
    chk("to_late_rvalid_resp", 32'(bt.resp_valid), 32'd0);
    @(negedge clk);
    chk("to_late_rvalid_resp2", 32'(bt.resp_valid), 32'd0);

    // Timeout with no grant; stray grant during RESP ignored
    bt_accept(32'h504);
    for (int i = 0; i < 4; i++) begin
      chk("to_b_mem_req_held", 32'(bt.mem_req), 32'd1);
      @(negedge clk);
    end
    chk("to_b_mem_req_drop", 32'(bt.mem_req), 32'd0);
    chk("to_b_cause", 32'(bt.resp_cause), 32'd3);
    bt.mem_gnt = 1'b1;
    bt_finish();
    bt.mem_gnt = 1'b0;
    chk("to_b_stray_gnt", 32'(bt.mem_req), 32'd0);

    // Bus error response
    bt_accept(32'h508);
    bt.mem_gnt = 1'b1;
    @(negedge clk);
    bt.mem_gnt = 1'b0; bt.mem_rvalid = 1'b1; bt.mem_err = 1'b1; bt.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bt.mem_rvalid = 1'b0; bt.mem_err = 1'b0;
    chk("to_c_err", 32'(bt.resp_err), 32'd1);
    chk("to_c_cause", 32'(bt.resp_cause), 32'd2);
    chk("to_c_rdata", bt.resp_rdata, 32'd0);
    bt_finish();

    // Response on the timeout cycle wins
    bt_accept(32'h50C);
    bt.mem_gnt = 1'b1;
    @(negedge clk);
    bt.mem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    rd = 32'hA1B2_C3D4;
    bt.mem_rvalid = 1'b1; bt.mem_rdata = rd;
    @(negedge clk);
    bt.mem_rvalid = 1'b0;
    chk("to_d_resp_valid", 32'(bt.resp_valid), 32'd1);
    chk("to_d_cause", 32'(bt.resp_cause), 32'd0);
    chk("to_d_rdata", bt.resp_rdata, m_load(3'd2, 32'h50C, rd));
    bt_finish();

    // Grant on the timeout cycle wins
    bt_accept(32'h510);
    repeat (3) @(negedge clk);
    bt.mem_gnt = 1'b1;
    @(negedge clk);
    bt.mem_gnt = 1'b0;
    chk("to_e_mem_req", 32'(bt.mem_req), 32'd0);
    chk("to_e_in_wait", 32'(bt.resp_valid), 32'd0);
    bt.mem_rvalid = 1'b1; bt.mem_rdata = 32'h0A0B_0C0D;
    @(negedge clk);
    bt.mem_rvalid = 1'b0;
    chk("to_e_resp_valid", 32'(bt.resp_valid), 32'd1);
    chk("to_e_cause", 32'(bt.resp_cause), 32'd0);
    chk("to_e_rdata", bt.resp_rdata, 32'h0D0C_0B0A);
    bt_finish();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
